// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: immediate format selects and field constants.
package legv8_pkg;

    localparam int unsigned INSN_FIELD_W = 26;
    localparam int unsigned SEU_W        = 3;
    localparam int unsigned BR_SHIFT     = 2;

    // Immediate format select; 3'b101..3'b111 are undefined encodings.
    typedef enum logic [SEU_W-1:0] {
        SEU_ALU_IMM = 3'b000,
        SEU_DT      = 3'b001,
        SEU_B       = 3'b010,
        SEU_CB      = 3'b011,
        SEU_MOVW    = 3'b100
    } seu_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate decode and extension for the LEGv8 formats.
// Ports:
//   address   : instruction bits [25:0]
//   seu       : format select (legv8_pkg::seu_e encoding)
//   bus_c     : extended immediate, DATA_W bits
//   illegal_c : format select is not a defined encoding
module imm_ext_comb
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [INSN_FIELD_W-1:0] address,
    input  logic [SEU_W-1:0]        seu,
    output logic [DATA_W-1:0]       bus_c,
    output logic                    illegal_c
);

    logic [DATA_W-1:0] sx_dt;
    logic [DATA_W-1:0] sx_b;
    logic [DATA_W-1:0] sx_cb;
    logic [DATA_W-1:0] mov_imm;
    logic [5:0]        mov_sh;

    // Sign-extended fields, before any branch scaling.
    assign sx_dt   = {{(DATA_W-9){address[20]}}, address[20:12]};
    assign sx_b    = {{(DATA_W-26){address[25]}}, address[25:0]};
    assign sx_cb   = {{(DATA_W-19){address[23]}}, address[23:5]};
    assign mov_imm = DATA_W'(address[20:5]);
    // MOVW shift amount is 16 * hw.
    assign mov_sh  = {address[22:21], 4'b0000};

    // Format mux; undefined selects give zero and raise illegal.
    always_comb begin
        bus_c     = '0;
        illegal_c = 1'b0;
        case (seu)
            SEU_ALU_IMM: bus_c = DATA_W'(address[21:10]);
            SEU_DT:      bus_c = sx_dt;
            SEU_B:       bus_c = sx_b << BR_SHIFT;
            SEU_CB:      bus_c = sx_cb << BR_SHIFT;
            SEU_MOVW: begin
                if (32'(mov_sh) >= DATA_W) begin
                    bus_c = '0;
                end else begin
                    bus_c = mov_imm << mov_sh;
                end
            end
            default:     illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage pipelined immediate extension and PC-relative target unit.
// Ports:
//   clk, rst            : clock, async active-high reset
//   flush               : synchronous kill of both stages; same-cycle input dropped
//   in_valid/in_ready   : input handshake (in_ready never depends on in_valid)
//   address, seu, pc, tag : input beat payload
//   out_valid/out_ready : output handshake; outputs held while stalled
//   bus, target         : extended immediate and pc + bus (mod 2^DATA_W)
//   out_tag, illegal    : passthrough tag and undefined-format flag
module imm_ext_pipe
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSN_FIELD_W-1:0] address,
    input  logic [SEU_W-1:0]        seu,
    input  logic [DATA_W-1:0]       pc,
    input  logic [TAG_W-1:0]        tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       bus,
    output logic [DATA_W-1:0]       target,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    illegal
);

    logic                    s1_valid;
    logic [INSN_FIELD_W-1:0] s1_address;
    logic [SEU_W-1:0]        s1_seu;
    logic [DATA_W-1:0]       s1_pc;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s2_advance_c;
    logic [DATA_W-1:0]       ext_bus_c;
    logic                    ext_illegal_c;
    logic [DATA_W-1:0]       target_c;

    // S2 is free when empty or its beat leaves this cycle.
    assign s2_advance_c = !out_valid || out_ready;
    assign in_ready     = !s1_valid || s2_advance_c;

    // Stage S1: capture the input beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_address <= '0;
            s1_seu     <= '0;
            s1_pc      <= '0;
            s1_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            // S1 is empty or moving on, so its next occupancy is the offered beat.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_address <= address;
                s1_seu     <= seu;
                s1_pc      <= pc;
                s1_tag     <= tag;
            end
        end
    end

    imm_ext_comb #(
        .DATA_W (DATA_W)
    ) u_ext (
        .address   (s1_address),
        .seu       (s1_seu),
        .bus_c     (ext_bus_c),
        .illegal_c (ext_illegal_c)
    );

    assign target_c = s1_pc + ext_bus_c;

    // Stage S2: register the computed beat; held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            bus       <= '0;
            target    <= '0;
            out_tag   <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_advance_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                bus     <= ext_bus_c;
                target  <= target_c;
                out_tag <= s1_tag;
                illegal <= ext_illegal_c;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe at DATA_W = 64 and DATA_W = 32.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [25:0] addr;
    logic [2:0]  seu;
    logic [63:0] pc_in;
    logic [4:0]  tag_in;

    logic        in_ready, out_valid, illegal;
    logic [63:0] bus, target;
    logic [4:0]  out_tag;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] bus32, target32;
    logic [4:0]  out_tag32;

    always #5 clk = ~clk;

    imm_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .address(addr), .seu(seu), .pc(pc_in), .tag(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .bus(bus), .target(target), .out_tag(out_tag), .illegal(illegal)
    );

    imm_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .address(addr), .seu(seu), .pc(pc_in[31:0]), .tag(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready),
        .bus(bus32), .target(target32), .out_tag(out_tag32), .illegal(illegal32)
    );

    typedef struct {
        logic [25:0] a;
        logic [2:0]  s;
        logic [63:0] pc;
        logic [4:0]  tag;
        int          acc;
    } beat_t;

    beat_t       sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    int          pop_cnt  = 0;
    bit          hold_chk = 1'b0;
    logic [63:0] h_bus, h_tgt;
    logic [4:0]  h_tag;
    logic        h_ill;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference extension from the format rules, using plain integer arithmetic.
    function automatic logic [63:0] ref_bus(input logic [25:0] a, input logic [2:0] s, input int w);
        longint      la, f, v;
        int          hw;
        logic [63:0] r;
        la = longint'({38'd0, a});
        v  = 0;
        case (s)
            3'd0: v = (la / 1024) % 4096;
            3'd1: begin f = (la / 4096) % 512; if (f >= 256) f = f - 512; v = f; end
            3'd2: begin f = la; if (f >= 33554432) f = f - 67108864; v = f * 4; end
            3'd3: begin f = (la / 32) % 524288; if (f >= 262144) f = f - 524288; v = f * 4; end
            3'd4: begin
                hw = int'((la / 2097152) % 4);
                f  = (la / 32) % 65536;
                if (16 * hw >= w) v = 0;
                else begin
                    for (int k = 0; k < hw; k++) f = f * 65536;
                    v = f;
                end
            end
            default: v = 0;
        endcase
        r = 64'(v);
        if (w == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    // One clock: check handshake/occupancy against the queue model, score outputs, advance.
    task automatic step(output bit acc);
        beat_t       b;
        logic [63:0] e64, e32;
        bit          exp_irdy, exp_ov;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            exp_irdy = (sb.size() < 2) || out_ready;
            exp_ov   = (sb.size() > 0) && (sb[0].acc < edge_cnt);
            check("in_ready", 64'(in_ready), 64'(exp_irdy));
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("in_ready32", 64'(in_ready32), 64'(exp_irdy));
            check("out_valid32", 64'(out_valid32), 64'(exp_ov));
            if (hold_chk) begin
                check("hold_bus", bus, h_bus);
                check("hold_target", target, h_tgt);
                check("hold_tag", 64'(out_tag), 64'(h_tag));
                check("hold_illegal", 64'(illegal), 64'(h_ill));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                b   = sb.pop_front();
                pop_cnt++;
                e64 = ref_bus(b.a, b.s, 64);
                e32 = ref_bus(b.a, b.s, 32);
                check("bus", bus, e64);
                check("target", target, b.pc + e64);
                check("out_tag", 64'(out_tag), 64'(b.tag));
                check("illegal", 64'(illegal), 64'(b.s > 3'd4));
                check("bus32", 64'(bus32), e32);
                check("target32", 64'(target32), (b.pc + e32) & 64'hFFFF_FFFF);
                check("illegal32", 64'(illegal32), 64'(b.s > 3'd4));
            end
            hold_chk = out_valid && !out_ready && !flush;
            h_bus = bus; h_tgt = target; h_tag = out_tag; h_ill = illegal;
            if (in_valid && in_ready && !flush) begin
                b.a = addr; b.s = seu; b.pc = pc_in; b.tag = tag_in; b.acc = edge_cnt + 1;
                sb.push_back(b);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        edge_cnt++;
        if (flush && !rst) begin
            sb.delete();
            hold_chk = 1'b0;
        end
        #1;
    endtask

    task automatic rand_beat(input logic [4:0] t, input int max_seu);
        addr   = 26'($urandom);
        seu    = 3'($urandom_range(0, max_seu));
        pc_in  = {32'($urandom), 32'($urandom)};
        tag_in = t;
    endtask

    // One isolated beat at pc = 0x1000, checked against fixed expected values.
    task automatic dir_beat(input logic [25:0] a, input logic [2:0] s,
                            input logic [63:0] eb64, input logic [31:0] eb32,
                            input logic ill, input logic [63:0] et64);
        bit acc;
        addr = a; seu = s; pc_in = 64'h1000; tag_in = 5'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        step(acc);
        in_valid = 1'b0;
        step(acc);
        check("dir_bus64", bus, eb64);
        check("dir_target64", target, et64);
        check("dir_bus32", 64'(bus32), 64'(eb32));
        check("dir_illegal", 64'(illegal), 64'(ill));
        check("dir_illegal32", 64'(illegal32), 64'(ill));
        step(acc);
    endtask

    initial begin
        bit acc;
        bit saw_block;
        int sent, cyc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        addr = '0; seu = '0; pc_in = '0; tag_in = '0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bus", bus, 64'd0);
        check("rst_target", target, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rel_in_ready", 64'(in_ready), 64'd1);

        // Per-format directed beats.
        dir_beat(26'h1FF << 12, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFF);
        dir_beat(26'h3FF_FFFF,  3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 64'hFFC);
        dir_beat(26'h1 << 5,    3'd3, 64'd4, 32'd4, 1'b0, 64'h1004);
        dir_beat(26'hFFF << 10, 3'd0, 64'hFFF, 32'hFFF, 1'b0, 64'h1FFF);
        dir_beat((26'd3 << 21) | (26'hABCD << 5), 3'd4, 64'hABCD_0000_0000_0000, 32'd0, 1'b0,
                 64'hABCD_0000_0000_1000);
        dir_beat((26'd2 << 21) | (26'hABCD << 5), 3'd4, 64'h0000_ABCD_0000_0000, 32'd0, 1'b0,
                 64'h0000_ABCD_0000_1000);
        dir_beat((26'd1 << 21) | (26'hABCD << 5), 3'd4, 64'hABCD_0000, 32'hABCD_0000, 1'b0,
                 64'hABCD_1000);
        for (int s = 5; s < 8; s++) dir_beat(26'h3FF_FFFF, 3'(s), 64'd0, 32'd0, 1'b1, 64'h1000);

        // Back-pressure: six tagged beats, out_ready pattern 1,0,0,1.
        pop_cnt = 0; sent = 0; cyc = 0; saw_block = 1'b0;
        while ((sent < 6 || sb.size() > 0) && cyc < 80) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 6);
            rand_beat(5'(sent + 1), 4);
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            step(acc);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_sent", 64'(sent), 64'd6);
        check("bp_popped", 64'(pop_cnt), 64'd6);
        check("bp_in_ready_dropped", 64'(saw_block), 64'd1);

        // Flush with both stages full, stalled consumer, input offered.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_beat(5'(20 + i), 4); in_valid = 1'b1; step(acc);
        end
        rand_beat(5'd9, 4); in_valid = 1'b1; flush = 1'b1;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        rand_beat(5'd10, 4); in_valid = 1'b1;
        step(acc);
        check("flush_next_acc", 64'(acc), 64'd1);
        in_valid = 1'b0;
        step(acc);
        check("flush_next_valid", 64'(out_valid), 64'd1);
        check("flush_next_tag", 64'(out_tag), 64'd10);
        step(acc);

        // Flush with both stages full and consumer ready: S2 beat consumed, offer dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_beat(5'(24 + i), 4); in_valid = 1'b1; step(acc);
        end
        out_ready = 1'b1; rand_beat(5'd11, 4); in_valid = 1'b1; flush = 1'b1;
        pop_cnt = 0;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_consumed", 64'(pop_cnt), 64'd1);
        check("flush2_out_valid", 64'(out_valid), 64'd0);
        repeat (3) step(acc);

        // Full throughput: 100 back-to-back beats.
        out_ready = 1'b1; pop_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            rand_beat(5'(i), 7); in_valid = 1'b1;
            step(acc);
            check("tp_accept", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) step(acc);
        check("tp_drained", 64'(sb.size()), 64'd0);
        check("tp_popped", 64'(pop_cnt), 64'd100);

        // Random mix of valid, ready and flush.
        for (int i = 0; i < 300; i++) begin
            rand_beat(5'($urandom), 7);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step(acc);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step(acc);

        // Reset mid-stream with two beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_beat(5'(i + 1), 4); addr = 26'h3FF_FFFF; in_valid = 1'b1; step(acc);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_bus", bus, 64'd0);
        check("mid_rst_target", target, 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_illegal", 64'(illegal), 64'd0);
        sb.delete();
        hold_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (3) step(acc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
